pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Frame-synchronous game-state controller for the HDMI pong design.
//  Sits between the video-timing/object/paddle blocks and the pixel mux.
//  Detects paddle hit/miss on the paddle row and tracks score and lives.
//  Serves a new ball after each miss and runs a timed GAME OVER pause.
//  Generalises the single-shot game-over logic to multi-life, scored play.
// PARAMETERS
//  VRES          720   active lines; the paddle row is VRES-PADDLE_H
//  PADDLE_H      20    paddle height in lines
//  LIVES         3     lives per game (1..15)
//  SCORE_W       10    score counter width; score saturates at 2**SCORE_W-1
//  SERVE_FRAMES  32    frames obj_rst is held after a non-final miss (>=1)
//  PAUSE_FRAMES  128   frames the GAME OVER overlay is held (>=1)
//  SPEEDUP_HITS  8     hits per speed level (only with PONG_SPEEDUP_EN)
// PORTS
//  pixel_clk      in   1        pixel clock; sole clock
//  rst_n          in   1        reset, asynchronous assert, active-low
//  fsync          in   1        1-cycle start-of-frame strobe
//  vpos           in   12 (s)   current line, signed
//  active_obj     in   1        ball covers current pixel
//  active_paddle  in   1        paddle covers current pixel
//  obj_rst        out  1        hold ball at serve position
//  paddle_rst     out  1        re-centre paddle
//  game_over      out  1        select GAME OVER overlay
//  hit_pulse      out  1        1-cycle strobe on a scored hit
//  miss_pulse     out  1        1-cycle strobe on a miss
//  score          out  SCORE_W  hits this game
//  lives          out  4        remaining lives
//  speed_level    out  3        ball speed index for the object block
// BEHAVIOUR
//  Reset values: state=S_ARM, score=0, lives=LIVES, speed_level=0, all 1-bit outs 0.
//  Registered FSM; all outputs are registered, so pulses appear 1 cycle after the event.
//  row_hit = (vpos == VRES-PADDLE_H) && active_obj.
//  S_ARM:   fsync -> S_WATCH.
//  S_WATCH: row_hit & active_paddle -> hit; row_hit & ~active_paddle -> S_PASS.
//  S_PASS:  active_obj & active_paddle -> hit; ~active_obj -> miss.
//           Overlap anywhere on the ball's row run counts as a hit. Hit takes
//           precedence over miss when both occur in the same cycle.
//  hit:  score+1 (saturating), hit_pulse, -> S_ARM, so at most 1 hit per frame.
//  miss: miss_pulse, lives-1. If lives was 1 -> S_OVER; otherwise -> S_SERVE.
//  S_SERVE: obj_rst=1; count SERVE_FRAMES fsyncs; then obj_rst=0 -> S_ARM.
//  S_OVER:  game_over=1, obj_rst=1, paddle_rst=1; count PAUSE_FRAMES fsyncs.
//           On the last one: score=0, lives=LIVES, speed_level=0, all outs 0 -> S_ARM.
//  fsync seen in S_WATCH/S_PASS: abandon evaluation, no miss, stay/return S_WATCH.
//  Inputs are ignored in S_SERVE and S_OVER. Frame counter clears on every state entry.
//  rst_n low mid-game: immediate async return to reset values; no pulses.
// CONFIGURATION
//  PONG_SPEEDUP_EN defined: a hit counter wraps every SPEEDUP_HITS hits and
//   increments speed_level (saturates at 7). The hit counter and speed_level
//   clear on game restart. speed_level is unchanged on a non-final miss.
//  PONG_SPEEDUP_EN undefined: speed_level tied 3'd0; no hit-counter logic built.
// STRUCTURE
//  pong_pkg: game_state_e {S_ARM,S_WATCH,S_PASS,S_SERVE,S_OVER}, HRES/VRES,
//   PADDLE_W/H and COLOR_* constants shared with object/paddle/top.
//  Sub-module pong_frame_timer: counts fsync up to a load value and issues a
//   done strobe; one instance, reused by S_SERVE and S_OVER.
// TESTING
//  1 Ball on paddle row with paddle overlapping the 3rd ball pixel -> hit_pulse x1, score 0->1, lives=3.
//  2 Ball row run with no paddle overlap -> miss_pulse, lives 3->2; obj_rst high for exactly 32 fsyncs.
//  3 Three misses -> game_over high for 128 fsyncs; then score=0, lives=3, game_over=0.
//  4 Score preset to 1023 plus a hit -> score stays 1023, hit_pulse still fires.
//  5 PONG_SPEEDUP_EN, 16 hits -> speed_level=2; without macro -> speed_level=0.
//  6 rst_n low in S_PASS and in S_OVER -> outputs at reset values in the same cycle; no pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the HDMI pong design.
// Used by the game controller, object, paddle and top-level pixel mux.
package pong_pkg;

    typedef enum logic [2:0] {
        S_ARM   = 3'd0,
        S_WATCH = 3'd1,
        S_PASS  = 3'd2,
        S_SERVE = 3'd3,
        S_OVER  = 3'd4
    } game_state_e;

    localparam int HRES     = 1280;
    localparam int VRES     = 720;
    localparam int PADDLE_W = 160;
    localparam int PADDLE_H = 20;

    localparam logic [23:0] COLOR_BG        = 24'h000000;
    localparam logic [23:0] COLOR_OBJ       = 24'hFFFFFF;
    localparam logic [23:0] COLOR_PADDLE    = 24'h00FF00;
    localparam logic [23:0] COLOR_GAME_OVER = 24'hFF0000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame timer: counts fsync strobes up to a load value and strobes done on
// the last one. Held cleared while clr is high so each use starts from zero.
module pong_frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] load,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = tick && !clr && (cnt == load - 1'b1);

    // Frame count; wraps to zero on completion or while cleared
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || done) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous game-state controller for the HDMI pong design.
// Detects paddle hit/miss on the paddle row, tracks score and lives,
// serves a new ball after each miss and runs a timed GAME OVER pause.
// Optional feature macro: PONG_SPEEDUP_EN (hit-driven ball speed levels).
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int VRES         = 720,
    parameter int PADDLE_H     = 20,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 10,
    parameter int SERVE_FRAMES = 32,
    parameter int PAUSE_FRAMES = 128,
    parameter int SPEEDUP_HITS = 8
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               fsync,
    input  logic signed [11:0] vpos,
    input  logic               active_obj,
    input  logic               active_paddle,
    output logic               obj_rst,
    output logic               paddle_rst,
    output logic               game_over,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic [2:0]         speed_level
);

    localparam logic signed [11:0] PADDLE_ROW = 12'(VRES - PADDLE_H);
    localparam int TMR_W = $clog2(max_int(SERVE_FRAMES, PAUSE_FRAMES) + 1);

    game_state_e      state;
    logic             row_hit;
    logic             hit_ev;
    logic             miss_ev;
    logic             restart;
    logic             tmr_clr;
    logic             tmr_done;
    logic [TMR_W-1:0] tmr_load;

    assign row_hit  = (vpos == PADDLE_ROW) && active_obj;
    // One timer serves both timed states; it is cleared outside them, which
    // is equivalent to clearing on every state entry.
    assign tmr_clr  = (state != S_SERVE) && (state != S_OVER);
    assign tmr_load = (state == S_OVER) ? TMR_W'(PAUSE_FRAMES) : TMR_W'(SERVE_FRAMES);
    assign restart  = (state == S_OVER) && tmr_done;

    pong_frame_timer #(
        .CNT_W (TMR_W)
    ) u_frame_timer (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .clr       (tmr_clr),
        .tick      (fsync),
        .load      (tmr_load),
        .done      (tmr_done)
    );

    // Hit/miss decision for the current pixel; a frame strobe abandons evaluation
    always_comb begin
        hit_ev  = 1'b0;
        miss_ev = 1'b0;
        if (!fsync) begin
            case (state)
                S_WATCH: hit_ev = row_hit && active_paddle;
                S_PASS: begin
                    hit_ev  = active_obj && active_paddle;
                    miss_ev = !active_obj;
                end
                default: ;
            endcase
        end
    end

    // Game FSM with registered outputs; pulses land one cycle after the event
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ARM;
            score      <= '0;
            lives      <= 4'(LIVES);
            obj_rst    <= 1'b0;
            paddle_rst <= 1'b0;
            game_over  <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (hit_ev) begin
                hit_pulse <= 1'b1;
                state     <= S_ARM;
                if (score != '1) begin
                    score <= score + 1'b1;
                end
            end else if (miss_ev) begin
                miss_pulse <= 1'b1;
                lives      <= lives - 1'b1;
                obj_rst    <= 1'b1;
                if (lives == 4'd1) begin
                    state      <= S_OVER;
                    game_over  <= 1'b1;
                    paddle_rst <= 1'b1;
                end else begin
                    state <= S_SERVE;
                end
            end else begin
                case (state)
                    S_ARM:   if (fsync) state <= S_WATCH;
                    S_WATCH: if (!fsync && row_hit) state <= S_PASS;
                    S_PASS:  if (fsync) state <= S_WATCH;
                    S_SERVE: begin
                        if (tmr_done) begin
                            obj_rst <= 1'b0;
                            state   <= S_ARM;
                        end
                    end
                    S_OVER: begin
                        if (restart) begin
                            score      <= '0;
                            lives      <= 4'(LIVES);
                            obj_rst    <= 1'b0;
                            paddle_rst <= 1'b0;
                            game_over  <= 1'b0;
                            state      <= S_ARM;
                        end
                    end
                    default: state <= S_ARM;
                endcase
            end
        end
    end

`ifdef PONG_SPEEDUP_EN
    localparam int HIT_W = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;

    logic [HIT_W-1:0] hit_cnt;

    // Raise the speed index once every SPEEDUP_HITS hits; cleared on game restart
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt     <= '0;
            speed_level <= '0;
        end else if (restart) begin
            hit_cnt     <= '0;
            speed_level <= '0;
        end else if (hit_ev) begin
            if (hit_cnt == HIT_W'(SPEEDUP_HITS - 1)) begin
                hit_cnt <= '0;
                if (speed_level != 3'd7) begin
                    speed_level <= speed_level + 3'd1;
                end
            end else begin
                hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end
`else
    // Speed index is fixed; SPEEDUP_HITS only matters when the feature is built
    localparam logic [2:0] SPEED_FIXED = (SPEEDUP_HITS > 0) ? 3'd0 : 3'd0;
    assign speed_level = SPEED_FIXED;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: table of ball-row scenarios plus
// hand-written sequences for serve/pause timing, saturation and async reset.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

    localparam int VRES         = 720;
    localparam int PADDLE_H     = 20;
    localparam int LIVES        = 3;
    localparam int SCORE_W      = 10;
    localparam int SERVE_FRAMES = 32;
    localparam int PAUSE_FRAMES = 128;
    localparam int SPEEDUP_HITS = 8;
    localparam int ROW          = VRES - PADDLE_H;
    localparam int SCORE_MAX    = (1 << SCORE_W) - 1;
`ifdef PONG_SPEEDUP_EN
    localparam int EXP_SPEED16  = 2;
`else
    localparam int EXP_SPEED16  = 0;
`endif

    logic               pixel_clk     = 1'b0;
    logic               rst_n         = 1'b0;
    logic               fsync         = 1'b0;
    logic signed [11:0] vpos          = '0;
    logic               active_obj    = 1'b0;
    logic               active_paddle = 1'b0;
    logic               obj_rst;
    logic               paddle_rst;
    logic               game_over;
    logic               hit_pulse;
    logic               miss_pulse;
    logic [SCORE_W-1:0] score;
    logic [3:0]         lives;
    logic [2:0]         speed_level;

    pong_game_ctrl #(
        .VRES         (VRES),
        .PADDLE_H     (PADDLE_H),
        .LIVES        (LIVES),
        .SCORE_W      (SCORE_W),
        .SERVE_FRAMES (SERVE_FRAMES),
        .PAUSE_FRAMES (PAUSE_FRAMES),
        .SPEEDUP_HITS (SPEEDUP_HITS)
    ) dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .fsync         (fsync),
        .vpos          (vpos),
        .active_obj    (active_obj),
        .active_paddle (active_paddle),
        .obj_rst       (obj_rst),
        .paddle_rst    (paddle_rst),
        .game_over     (game_over),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .score         (score),
        .lives         (lives),
        .speed_level   (speed_level)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        bit hit;
        int score;
        int lives;
        int speed;
    } exp_t;

    typedef struct {
        int len;   // ball pixels on the run
        int pad;   // run index where the paddle overlaps (len = just after the run, -1 = never)
        int row;   // line the ball run sits on
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   exp_score = 0;
    int   exp_lives = LIVES;
    int   exp_hits = 0;

    function automatic int exp_speed();
`ifdef PONG_SPEEDUP_EN
        return (exp_hits / SPEEDUP_HITS > 7) ? 7 : exp_hits / SPEEDUP_HITS;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_score = 0;
        exp_lives = LIVES;
        exp_hits  = 0;
        sb.delete();
    endtask

    // Advance one clock, sample 1ns later and retire any pulse against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge pixel_clk);
        #1;
        if (hit_pulse === 1'b1 || miss_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pulse: hit=%b miss=%b, none expected", hit_pulse, miss_pulse);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {30'd0, hit_pulse, miss_pulse}, e.hit ? 32'd2 : 32'd1);
                check("pulse_score", 32'(score), e.score);
                check("pulse_lives", 32'(lives), e.lives);
                check("pulse_speed", 32'(speed_level), e.speed);
            end
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_score"}, 32'(score), 0);
        check({name, "_lives"}, 32'(lives), LIVES);
        check({name, "_speed"}, 32'(speed_level), 0);
        check({name, "_flags"}, {26'd0, obj_rst, paddle_rst, game_over, hit_pulse, miss_pulse, 1'b0}, 0);
    endtask

    task automatic serve_wait();
        int n = 0;
        check("serve_obj_rst", 32'(obj_rst), 1);
        check("serve_no_overlay", 32'(game_over), 0);
        while (obj_rst === 1'b1 && n < 1000) begin
            fsync = 1'b1; tick(); fsync = 1'b0;
            n++;
            tick();
        end
        check("serve_frames", n, SERVE_FRAMES);
    endtask

    task automatic over_wait();
        int n = 0;
        check("over_flags", {29'd0, game_over, obj_rst, paddle_rst}, 7);
        while (game_over === 1'b1 && n < 1000) begin
            fsync = 1'b1; tick(); fsync = 1'b0;
            n++;
            tick();
        end
        check("over_frames", n, PAUSE_FRAMES);
        check_reset("restart");
        exp_score = 0;
        exp_lives = LIVES;
        exp_hits  = 0;
    endtask

    // One frame: arm on fsync, then present the ball run and model the outcome
    task automatic run_vec(input vec_t v, input bit hold_over);
        bit decided = 1'b0;
        bit missed  = 1'b0;
        fsync = 1'b1; tick(); fsync = 1'b0;
        vpos = 12'sd100; tick();
        for (int i = 0; i <= v.len && !decided; i++) begin
            vpos          = 12'(v.row);
            active_obj    = (i < v.len);
            active_paddle = (i == v.pad);
            if (v.row == ROW) begin
                if (active_obj && active_paddle) begin
                    decided   = 1'b1;
                    exp_score = (exp_score == SCORE_MAX) ? SCORE_MAX : exp_score + 1;
                    exp_hits++;
                    sb.push_back('{1'b1, exp_score, exp_lives, exp_speed()});
                end else if (!active_obj) begin
                    decided = 1'b1;
                    missed  = 1'b1;
                    exp_lives--;
                    sb.push_back('{1'b0, exp_score, exp_lives, exp_speed()});
                end
            end
            tick();
        end
        active_obj = 1'b0; active_paddle = 1'b0; vpos = '0;
        if (missed) begin
            if (exp_lives > 0) serve_wait();
            else if (!hold_over) over_wait();
        end
        tick();
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{5, 2, ROW};      // paddle on 3rd ball pixel: hit
        vecs[1] = '{4, -1, ROW};     // no overlap: miss, serve
        vecs[2] = '{3, 0, ROW};      // overlap on first pixel
        vecs[3] = '{3, 2, ROW};      // overlap on last pixel
        vecs[4] = '{4, -1, ROW - 1}; // not the paddle row: nothing
        vecs[5] = '{3, 3, ROW};      // paddle only after the run: miss
        vecs[6] = '{6, 5, ROW};      // hit after a long run
        vecs[7] = '{2, -1, ROW};     // final life: game over pause
        vecs[8] = '{4, 1, ROW};      // first hit of new game
        vecs[9] = '{2, -1, ROW + 1}; // below paddle row: nothing

        tick(); tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();
        check_reset("post_reset");

        for (int k = 0; k < 10; k++) run_vec(vecs[k], 1'b0);
        check("table_score", 32'(score), 1);
        check("table_lives", 32'(lives), 3);

        // fsync in S_PASS abandons evaluation: no miss, back to watching
        fsync = 1'b1; tick(); fsync = 1'b0;
        vpos = 12'(ROW); active_obj = 1'b1; tick();
        active_obj = 1'b0; fsync = 1'b1; tick(); fsync = 1'b0;
        tick(); tick();
        check("abandon_lives", 32'(lives), exp_lives);
        vpos = 12'(ROW); active_obj = 1'b1; active_paddle = 1'b1;
        exp_score++; exp_hits++;
        sb.push_back('{1'b1, exp_score, exp_lives, exp_speed()});
        tick();
        active_obj = 1'b0; active_paddle = 1'b0; vpos = '0;
        tick();
        check("abandon_then_hit", sb.size(), 0);

        // async reset while in S_PASS
        run_vec('{2, -1, ROW}, 1'b0);
        fsync = 1'b1; tick(); fsync = 1'b0;
        vpos = 12'(ROW); active_obj = 1'b1; tick();
        #2 rst_n = 1'b0;
        #1 check_reset("rst_pass");
        active_obj = 1'b0;
        tick(); tick(); tick();
        model_reset();
        rst_n = 1'b1;
        tick();
        check_reset("rst_pass_release");

        // speed levels after 16 hits, then score saturation
        for (int k = 0; k < 16; k++) run_vec('{1, 0, ROW}, 1'b0);
        check("speed_16_hits", 32'(speed_level), EXP_SPEED16);
        while (exp_score < SCORE_MAX) run_vec('{1, 0, ROW}, 1'b0);
        check("score_max", 32'(score), SCORE_MAX);
        run_vec('{2, 1, ROW}, 1'b0);
        check("score_saturated", 32'(score), SCORE_MAX);

        // async reset in the middle of the GAME OVER pause
        run_vec('{2, -1, ROW}, 1'b0);
        run_vec('{2, -1, ROW}, 1'b0);
        run_vec('{2, -1, ROW}, 1'b1);
        for (int k = 0; k < 5; k++) begin
            fsync = 1'b1; tick(); fsync = 1'b0; tick();
        end
        check("over_hold", {29'd0, game_over, obj_rst, paddle_rst}, 7);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_over");
        tick(); tick();
        model_reset();
        rst_n = 1'b1;
        tick();
        check_reset("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
